// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
// Mode codes, FSM state encoding and one-hot to binary conversion.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAXN       = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // OR of set positions; exact for one-hot or zero input
  function automatic logic [7:0] onehot_to_idx(
    input logic [MAXN-1:0] oh
  );
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational first-set-bit search from a start pointer.
// Search wraps N-1 -> 0; start is ignored unless rr_en is set.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] start,
  input  logic            rr_en,
  output logic            found,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    onehot
);

  always_comb begin
    int base;
    int jj;
    logic [IDXW-1:0] j;
    found  = 1'b0;
    onehot = '0;
    jj     = 0;
    j      = '0;
    base   = rr_en ? int'(start) : 0;
    for (int k = 0; k < N; k++) begin
      jj = base + k;
      if (jj >= N) jj = jj - N;
      j = IDXW'(jj);
      if (!found && vec[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
      end
    end
    idx = IDXW'(onehot_to_idx(MAXN'(onehot)));
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority arbiter, fixed or round-robin.
// Grant is held until accepted; back-to-back grants on handshake.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            grant_ready,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic [N-1:0]    grant_onehot,
  output logic [N-1:0]    ack,
  output logic [IDXW-1:0] rr_ptr
);

  state_t          state;
  logic            hs;
  logic            found;
  logic [IDXW-1:0] pidx;
  logic [N-1:0]    poh;
  logic [N-1:0]    pvec;
  logic [IDXW-1:0] nxt_ptr;

  assign hs   = grant_valid & grant_ready;
  assign ack  = grant_onehot & {N{hs}};
  // just-served source is masked so it cannot win twice in a row
  assign pvec = (state == GRANT) ? (req & ~grant_onehot) : req;
  assign nxt_ptr = (grant_idx == IDXW'(N - 1)) ? '0
                 : grant_idx + IDXW'(1);

  prio_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .vec    (pvec),
    .start  (rr_ptr),
    .rr_en  (mode == MODE_RR),
    .found  (found),
    .idx    (pidx),
    .onehot (poh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state        <= GRANT;
            grant_valid  <= 1'b1;
            grant_idx    <= pidx;
            grant_onehot <= poh;
          end
        end
        GRANT: begin
          if (hs) begin
            if (mode == MODE_RR) rr_ptr <= nxt_ptr;
            if (found) begin
              grant_idx    <= pidx;
              grant_onehot <= poh;
            end else begin
              state        <= IDLE;
              grant_valid  <= 1'b0;
              grant_onehot <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr, N=4 and N=8 side by side.
// Reference model predicts each cycle; results are queued and popped.
module tb_prio_encoder_rr;

  typedef struct packed {
    logic       v;
    logic [7:0] idx;
    logic [7:0] oh;
    logic [7:0] ptr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       rdy;

  logic       v4, v8;
  logic [1:0] idx4, ptr4;
  logic [2:0] idx8, ptr8;
  logic [3:0] oh4, ack4;
  logic [7:0] oh8, ack8;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req[3:0]),
    .mode         (mode),
    .grant_ready  (rdy),
    .grant_valid  (v4),
    .grant_idx    (idx4),
    .grant_onehot (oh4),
    .ack          (ack4),
    .rr_ptr       (ptr4)
  );

  prio_encoder_rr #(.N(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .grant_ready  (rdy),
    .grant_valid  (v8),
    .grant_idx    (idx8),
    .grant_onehot (oh8),
    .ack          (ack8),
    .rr_ptr       (ptr8)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   mv[2], midx[2], moh[2], mptr[2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int vec, int n, int start);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (start + k) % n;
      if (((vec >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; midx[i] = 0; moh[i] = 0; mptr[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int n, vec, w, old;
    n   = (i == 0) ? 4 : 8;
    vec = int'(req) & ((1 << n) - 1);
    if (!rst_n) begin
      mv[i] = 0; midx[i] = 0; moh[i] = 0; mptr[i] = 0;
    end else if (mv[i] == 0) begin
      w = pick(vec, n, mode ? mptr[i] : 0);
      if (w >= 0) begin
        mv[i] = 1; midx[i] = w; moh[i] = 1 << w;
      end
    end else if (rdy) begin
      old = mptr[i];
      if (mode) mptr[i] = (midx[i] + 1) % n;
      w = pick(vec & ~moh[i], n, mode ? old : 0);
      if (w >= 0) begin
        midx[i] = w; moh[i] = 1 << w;
      end else begin
        mv[i] = 0; moh[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] ack_exp(input int i);
    return (mv[i] != 0 && rdy) ? 32'(moh[i]) : 32'd0;
  endfunction

  task automatic cmp_out(input int i);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (i == 0) begin
      chk("valid4", 32'(v4), 32'(e.v));
      chk("idx4", 32'(idx4), 32'(e.idx));
      chk("onehot4", 32'(oh4), 32'(e.oh));
      chk("rrptr4", 32'(ptr4), 32'(e.ptr));
    end else begin
      chk("valid8", 32'(v8), 32'(e.v));
      chk("idx8", 32'(idx8), 32'(e.idx));
      chk("onehot8", 32'(oh8), 32'(e.oh));
      chk("rrptr8", 32'(ptr8), 32'(e.ptr));
    end
  endtask

  // one clock: drive, check ack, predict, clock, compare
  task automatic cyc(input logic [7:0] r,
                     input logic m,
                     input logic rd);
    exp_t e;
    req  = r;
    mode = m;
    rdy  = rd;
    #1;
    chk("ack4", 32'(ack4), ack_exp(0));
    chk("ack8", 32'(ack8), ack_exp(1));
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      e.v   = (mv[i] != 0);
      e.idx = 8'(midx[i]);
      e.oh  = 8'(moh[i]);
      e.ptr = 8'(mptr[i]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmp_out(0);
    cmp_out(1);
    @(negedge clk);
  endtask

  task automatic seq_fixed();
    cyc(8'h0a, 1'b0, 1'b1);
    cyc(8'h0a, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
  endtask

  task automatic seq_rr();
    for (int k = 0; k < 9; k++) cyc(8'hff, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    req   = 8'h0f;
    mode  = 1'b0;
    rdy   = 1'b0;
    @(negedge clk);
    // reset held with all requests active
    cyc(8'h0f, 1'b0, 1'b0);
    cyc(8'h0f, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(8'h0f, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);

    seq_fixed();

    // hold while not ready, request dropped after one cycle
    cyc(8'h04, 1'b0, 1'b0);
    cyc(8'h04, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);

    seq_rr();

    // pointer to 3, then wrap to 0 and skip to 1
    cyc(8'h04, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h03, 1'b1, 1'b1);
    cyc(8'h03, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);

    // mode flips while grant is held
    cyc(8'h06, 1'b1, 1'b0);
    cyc(8'h06, 1'b0, 1'b0);
    cyc(8'h06, 1'b0, 1'b1);
    cyc(8'h06, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1);

    // async reset pulse between edges during a grant
    cyc(8'h0f, 1'b1, 1'b0);
    rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_v4", 32'(v4), 32'd0);
    chk("async_oh4", 32'(oh4), 32'd0);
    chk("async_ack4", 32'(ack4), 32'd0);
    chk("async_v8", 32'(v8), 32'd0);
    chk("async_oh8", 32'(oh8), 32'd0);
    chk("async_ack8", 32'(ack8), 32'd0);
    chk("async_ptr8", 32'(ptr8), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    cyc(8'h00, 1'b0, 1'b1);

    seq_fixed();
    seq_rr();

    for (int k = 0; k < 60; k++) begin
      cyc(8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
